// File: rtl/regread_pkg.sv
// Shared defaults and the FSM state encoding for the register-file read scoreboard.
package regread_pkg;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_STALL_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/register1bit.sv
// Single tracking bit with independent set and clear; set wins when both fire on one edge.
module register1bit (
  input  logic clk,
  input  logic reset,
  input  logic setEn,
  input  logic clrEn,
  output logic q
);

  // Hold the bit; a newer writer (set) overrides a retiring one (clear).
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(negedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (setEn) begin
      q <= 1'b1;
    end else if (clrEn) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/regread_pending_mask.sv
// One in-flight-write bit per architectural register, with two combinational lookup ports.
module regread_pending_mask
  import regread_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] lookup_addr1,
  input  logic [ADDR_W-1:0] lookup_addr2,
  output logic              lookup1,
  output logic              lookup2
);

  logic [NUM_REGS-1:0] mask;

  // NOTE: the mask is a handful of flops, not a RAM, so every bit is reset to "nothing in flight".
  for (genvar i = 0; i < NUM_REGS; i++) begin : gCell
    register1bit uCell (
      .clk   (clk),
      .reset (reset),
      .setEn (set_en && (set_addr == ADDR_W'(i))),
      .clrEn (clr_en && (clr_addr == ADDR_W'(i))),
      .q     (mask[i])
    );
  end

  assign lookup1 = mask[lookup_addr1];
  assign lookup2 = mask[lookup_addr2];

endmodule

// File: rtl/regfile_read_scoreboard.sv
// Read side of the VLIW register file: accepts one instruction, holds it while either
// source has an in-flight write, then presents the operand pair over valid/ready.
// All state changes on the falling clock edge, matching the register file.
// Optional feature: define REGREAD_BYPASS_EN to forward same-edge writeback data into
// the operands instead of waiting one extra cycle for the register file to update.
module regfile_read_scoreboard
  import regread_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int STALL_W  = DEF_STALL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [ADDR_W-1:0]  issue_rs1,
  input  logic [ADDR_W-1:0]  issue_rs2,
  input  logic [ADDR_W-1:0]  issue_rd,
  input  logic               issue_rd_en,
  output logic [ADDR_W-1:0]  rf_rd_addr1,
  output logic [ADDR_W-1:0]  rf_rd_addr2,
  input  logic [DATA_W-1:0]  rf_rd_data1,
  input  logic [DATA_W-1:0]  rf_rd_data2,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [DATA_W-1:0]  op_a,
  output logic [DATA_W-1:0]  op_b,
  output logic [ADDR_W-1:0]  op_rd,
  output logic               op_rd_en,
  output logic [STALL_W-1:0] stall_cnt
);

  state_t state, stateNext;

  logic [ADDR_W-1:0] rs1Q, rs2Q, rdQ;
  logic              rdEnQ;
  logic [ADDR_W-1:0] src1, src2;
  logic              pend1, pend2;
  logic              clr1, clr2;
  logic              hazard;
  logic              accept, capture, deliver;

  assign issue_ready = (state == IDLE);
  assign op_valid    = (state == OUT);
  assign accept      = issue_valid & issue_ready;
  assign deliver     = op_valid & op_ready;

  // In IDLE the incoming instruction is read directly; afterwards the held one is re-read.
  assign src1        = (state == IDLE) ? issue_rs1 : rs1Q;
  assign src2        = (state == IDLE) ? issue_rs2 : rs2Q;
  assign rf_rd_addr1 = src1;
  assign rf_rd_addr2 = src2;

`ifdef REGREAD_BYPASS_EN
  assign clr1 = wb_valid && (wb_addr == src1);
  assign clr2 = wb_valid && (wb_addr == src2);
`else
  assign clr1 = 1'b0;
  assign clr2 = 1'b0;
`endif

  assign hazard  = (pend1 & ~clr1) | (pend2 & ~clr2);
  assign capture = (accept | (state == WAIT)) & ~hazard;

  // Retiring writes clear their bit; the instruction leaving for execute marks its destination.
  regread_pending_mask #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) uPending (
    .clk          (clk),
    .reset        (reset),
    .set_en       (deliver & rdEnQ),
    .set_addr     (rdQ),
    .clr_en       (wb_valid),
    .clr_addr     (wb_addr),
    .lookup_addr1 (src1),
    .lookup_addr2 (src2),
    .lookup1      (pend1),
    .lookup2      (pend2)
  );

  // State register.
  always_ff @(negedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: accept, wait out hazards, then hand off to execute.
  // NOTE: stateNext gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = hazard ? WAIT : OUT;
      WAIT:    if (!hazard) stateNext = OUT;
      OUT:     if (op_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Latch the accepted instruction, capture operands once hazard-free, count stall cycles.
  always_ff @(negedge clk) begin
    if (reset) begin
      rs1Q      <= '0;
      rs2Q      <= '0;
      rdQ       <= '0;
      rdEnQ     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        rs1Q  <= issue_rs1;
        rs2Q  <= issue_rs2;
        rdQ   <= issue_rd;
        rdEnQ <= issue_rd_en;
      end
      if (capture) begin
        op_a <= clr1 ? wb_data : rf_rd_data1;
        op_b <= clr2 ? wb_data : rf_rd_data2;
      end
      if ((state == WAIT) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

  // Destination fields are latched at accept and stay put until the next accept.
  assign op_rd    = rdQ;
  assign op_rd_en = rdEnQ;

endmodule

// File: tb/tb_regfile_read_scoreboard.sv
// Self-checking bench for regfile_read_scoreboard: an instruction-slot model predicts every
// output each cycle, plus directed scenarios with literal expectations.
module tb_regfile_read_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issueValid, issueRdEn, opReady, wbValid;
  logic [2:0]  issueRs1, issueRs2, issueRd, wbAddr;
  logic [31:0] wbData;

  logic        issueReady, opValid, opRdEn;
  logic [2:0]  rfRdAddr1, rfRdAddr2, opRd;
  logic [31:0] rfRdData1, rfRdData2, opA, opB;
  logic [15:0] stallCnt;

  logic        issueReadySat, opValidSat, opRdEnSat;
  logic [2:0]  rfRdAddr1Sat, rfRdAddr2Sat, opRdSat;
  logic [31:0] rfRdData1Sat, rfRdData2Sat, opASat, opBSat;
  logic [3:0]  stallCntSat;

  logic [31:0] rf [8];

  int checks = 0;
  int failures = 0;
  int stallBase = 0;

  always #5 clk = ~clk;

  assign rfRdData1    = rf[rfRdAddr1];
  assign rfRdData2    = rf[rfRdAddr2];
  assign rfRdData1Sat = rf[rfRdAddr1Sat];
  assign rfRdData2Sat = rf[rfRdAddr2Sat];

  regfile_read_scoreboard #(.STALL_W(16)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issueValid), .issue_ready(issueReady),
    .issue_rs1(issueRs1), .issue_rs2(issueRs2), .issue_rd(issueRd), .issue_rd_en(issueRdEn),
    .rf_rd_addr1(rfRdAddr1), .rf_rd_addr2(rfRdAddr2),
    .rf_rd_data1(rfRdData1), .rf_rd_data2(rfRdData2),
    .wb_valid(wbValid), .wb_addr(wbAddr), .wb_data(wbData),
    .op_valid(opValid), .op_ready(opReady), .op_a(opA), .op_b(opB),
    .op_rd(opRd), .op_rd_en(opRdEn), .stall_cnt(stallCnt)
  );

  regfile_read_scoreboard #(.STALL_W(4)) dutSat (
    .clk(clk), .reset(reset),
    .issue_valid(issueValid), .issue_ready(issueReadySat),
    .issue_rs1(issueRs1), .issue_rs2(issueRs2), .issue_rd(issueRd), .issue_rd_en(issueRdEn),
    .rf_rd_addr1(rfRdAddr1Sat), .rf_rd_addr2(rfRdAddr2Sat),
    .rf_rd_data1(rfRdData1Sat), .rf_rd_data2(rfRdData2Sat),
    .wb_valid(wbValid), .wb_addr(wbAddr), .wb_data(wbData),
    .op_valid(opValidSat), .op_ready(opReady), .op_a(opASat), .op_b(opBSat),
    .op_rd(opRdSat), .op_rd_en(opRdEnSat), .stall_cnt(stallCntSat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one instruction slot ----------------
  bit          modelLive = 1'b0;
  bit          mHeld, mReady, mRdEn;
  logic [2:0]  mRs1, mRs2, mRd;
  logic [31:0] mA, mB;
  bit   [7:0]  pend;
  int          mStall;

  always @(negedge clk) begin
    logic [2:0] s1, s2;
    bit c1, c2, delivered;
    if (reset) begin
      mHeld = 0; mReady = 0; mRdEn = 0; mRs1 = 0; mRs2 = 0; mRd = 0;
      mA = 0; mB = 0; pend = '0; mStall = 0;
      modelLive = 1'b1;
      for (int i = 0; i < 8; i++) rf[i] <= 32'h11 * 32'(i);
    end else begin
      s1 = mHeld ? mRs1 : issueRs1;
      s2 = mHeld ? mRs2 : issueRs2;
`ifdef REGREAD_BYPASS_EN
      c1 = wbValid && (wbAddr == s1);
      c2 = wbValid && (wbAddr == s2);
`else
      c1 = 0;
      c2 = 0;
`endif
      delivered = 0;
      if (mHeld && mReady) begin
        if (opReady) begin
          delivered = 1; mHeld = 0; mReady = 0;
        end
      end else if (mHeld || issueValid) begin
        if (mHeld) mStall++;
        else begin
          mRs1 = issueRs1; mRs2 = issueRs2; mRd = issueRd; mRdEn = issueRdEn;
        end
        mHeld = 1;
        if (!((pend[s1] && !c1) || (pend[s2] && !c2))) begin
          mReady = 1;
          mA = c1 ? wbData : rf[s1];
          mB = c2 ? wbData : rf[s2];
        end
      end
      if (wbValid) pend[wbAddr] = 1'b0;
      if (delivered && mRdEn) pend[mRd] = 1'b1;
      if (wbValid) rf[wbAddr] <= wbData;
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(posedge clk) begin
    if (modelLive) begin
      check("issue_ready", issueReady, !mHeld);
      check("op_valid", opValid, mHeld && mReady);
      check("rf_rd_addr1", rfRdAddr1, mHeld ? mRs1 : issueRs1);
      check("rf_rd_addr2", rfRdAddr2, mHeld ? mRs2 : issueRs2);
      check("stall_cnt", stallCnt, (mStall > 65535) ? 65535 : mStall);
      check("stall_cnt_w4", stallCntSat, (mStall > 15) ? 15 : mStall);
      check("op_valid_w4", opValidSat, mHeld && mReady);
      if (mHeld && mReady) begin
        check("op_a", opA, mA);
        check("op_b", opB, mB);
        check("op_rd", opRd, mRd);
        check("op_rd_en", opRdEn, mRdEn);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic rdEn);
    issueValid = 1'b1; issueRs1 = rs1; issueRs2 = rs2; issueRd = rd; issueRdEn = rdEn;
  endtask

  initial begin
    reset = 1'b1; issueValid = 0; issueRs1 = 0; issueRs2 = 0; issueRd = 0; issueRdEn = 0;
    opReady = 0; wbValid = 0; wbAddr = 0; wbData = 0;
    cyc(2);
    check("reset issue_ready", issueReady, 1);
    check("reset op_valid", opValid, 0);
    check("reset stall_cnt", stallCnt, 0);
    check("reset op_a", opA, 0);
    check("reset op_rd_en", opRdEn, 0);
    reset = 1'b0;

    // 1: hazard-free issue, operands one cycle later
    issue(3'd1, 3'd2, 3'd0, 1'b0); opReady = 1;
    cyc();
    issueValid = 0;
    check("t1 op_valid", opValid, 1);
    check("t1 op_a", opA, 32'h11);
    check("t1 op_b", opB, 32'h22);
    cyc();
    check("t1 back to idle", issueReady, 1);

    // 2: RAW on r3, writeback four cycles after accept
    issue(3'd0, 3'd0, 3'd3, 1'b1);
    cyc();
    issueValid = 0;
    cyc();
    issue(3'd3, 3'd1, 3'd4, 1'b0);
    cyc();
    issueValid = 0;
    check("t2 stalled", opValid, 0);
    check("t2 busy", issueReady, 0);
    cyc(3);
    check("t2 stall 3", stallCnt, 3);
    wbValid = 1; wbAddr = 3'd3; wbData = 32'hAB;
    cyc();
    wbValid = 0;
`ifdef REGREAD_BYPASS_EN
    check("t2 op_valid", opValid, 1);
    check("t2 op_a", opA, 32'hAB);
    check("t2 op_b", opB, 32'h11);
    check("t2 stall", stallCnt, 4);
    stallBase = 4;
`else
    check("t2 extra wait", opValid, 0);
    check("t2 stall", stallCnt, 4);
    cyc();
    check("t2 op_valid", opValid, 1);
    check("t2 op_a", opA, 32'hAB);
    check("t2 op_b", opB, 32'h11);
    check("t2 stall final", stallCnt, 5);
    stallBase = 5;
`endif
    cyc();
    check("t2 back to idle", issueReady, 1);

    // 3: backpressure for five cycles while another issue waits
    opReady = 0;
    issue(3'd4, 3'd5, 3'd6, 1'b1);
    cyc();
    issue(3'd7, 3'd7, 3'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t3 held valid", opValid, 1);
      check("t3 held op_a", opA, 32'h44);
      check("t3 held op_b", opB, 32'h55);
      check("t3 held op_rd", opRd, 3'd6);
      check("t3 not ready", issueReady, 0);
      cyc();
    end
    issueValid = 0; opReady = 1;
    cyc();
    check("t3 released", opValid, 0);
    check("t3 idle", issueReady, 1);

    // 4: dispatch r5 on the same edge as a writeback to r5 -> r5 stays pending
    opReady = 0;
    issue(3'd0, 3'd0, 3'd5, 1'b1);
    cyc();
    issueValid = 0; opReady = 1;
    wbValid = 1; wbAddr = 3'd5; wbData = 32'h5555;
    cyc();
    wbValid = 0;
    issue(3'd5, 3'd5, 3'd0, 1'b0);
    cyc();
    issueValid = 0;
    check("t4 stalls", opValid, 0);
    cyc(2);
    check("t4 still stalled", opValid, 0);
    check("t4 stall count", stallCnt, 16'(stallBase + 2));

    // 5: reset while in WAIT
    reset = 1'b1;
    cyc();
    check("t5 op_valid", opValid, 0);
    check("t5 stall_cnt", stallCnt, 0);
    check("t5 issue_ready", issueReady, 1);
    reset = 1'b0;
    issue(3'd5, 3'd6, 3'd0, 1'b0); opReady = 1;
    cyc();
    issueValid = 0;
    check("t5 no pending left", opValid, 1);
    check("t5 op_a", opA, 32'h55);
    check("t5 op_b", opB, 32'h66);
    cyc();

    // 6: 20 WAIT cycles saturate a 4-bit counter
    issue(3'd0, 3'd0, 3'd2, 1'b1);
    cyc();
    issueValid = 0;
    cyc();
    issue(3'd2, 3'd3, 3'd0, 1'b0);
    cyc();
    issueValid = 0;
    cyc(20);
    check("t6 stall 16b", stallCnt, 20);
    check("t6 stall 4b sat", stallCntSat, 15);
    wbValid = 1; wbAddr = 3'd2; wbData = 32'h2222;
    cyc();
    wbValid = 0;
    cyc(3);
    check("t6 drained", issueReady, 1);
    check("t6 sat held", stallCntSat, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
